// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the 16-bit Hamming SECDED receive path:
// FSM states, status flag codes and the data-bit placement inside a codeword.
package hamming_decoder_pkg;

  typedef enum logic [2:0] {
    GET_MSW = 3'd0,
    GET_LSW = 3'd1,
    DECODE  = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } dec_state_t;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_SEC = 2'b01;
  localparam logic [1:0] F_DED = 2'b10;

  // Codeword positions of data bits b1..b11; entry [0] is b1
  localparam logic [10:0][3:0] DATA_POS = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  function automatic logic [10:0] extract_data(input logic [15:0] word);
    logic [10:0] data;
    data = '0;
    for (int i = 0; i < 11; i++) begin
      data[i] = word[DATA_POS[i]];
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED checker: syndrome over positions 1..15 and overall parity.
// Kept separate so an encoder-side self-check can reuse it.
module hamming_syndrome (
  input  logic [15:0] word,
  output logic [3:0]  syndrome,
  output logic        parity
);

  always_comb begin
    syndrome = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (word[i]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
    parity = ^word;
  end

endmodule

// File: rtl/hamming_decoder.sv
// Byte-stream SECDED decoder: gathers MSW/LSW, corrects or flags errors,
// and returns a status+data byte pair with saturating error counters.
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [W-1:0]     InByte,
  input  logic             InValid,
  output logic             InReady,
  output logic [W-1:0]     OutByte,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CNT_W-1:0] SecCnt,
  output logic [CNT_W-1:0] DedCnt
);

  dec_state_t       state;
  dec_state_t       state_next;
  logic             msw_load;
  logic             lsw_load;
  logic             do_decode;

  logic [W-1:0]     msw_q;
  logic [W-1:0]     lsw_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  logic [15:0]      word;
  logic [15:0]      fixed_word;
  logic [3:0]       syndrome;
  logic             parity;
  logic [1:0]       flags;
  logic [10:0]      data;

  assign word = {msw_q, lsw_q};

  hamming_syndrome u_syndrome (
    .word     (word),
    .syndrome (syndrome),
    .parity   (parity)
  );

  // A p0-only error needs no data change; a double error passes data through raw
  always_comb begin
    fixed_word = word;
    flags      = F_OK;
    if (syndrome != 4'd0 && parity) begin
      flags                = F_SEC;
      fixed_word[syndrome] = ~word[syndrome];
    end else if (syndrome == 4'd0 && parity) begin
      flags = F_SEC;
    end else if (syndrome != 4'd0 && !parity) begin
      flags = F_DED;
    end
    data = extract_data(fixed_word);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= GET_MSW;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    msw_load   = 1'b0;
    lsw_load   = 1'b0;
    do_decode  = 1'b0;
    case (state)
      GET_MSW: begin
        if (InValid) begin
          msw_load   = 1'b1;
          state_next = GET_LSW;
        end
      end
      GET_LSW: begin
        if (InValid) begin
          lsw_load   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        do_decode  = 1'b1;
        state_next = SEND_HI;
      end
      SEND_HI: begin
        if (OutReady) begin
          state_next = SEND_LO;
        end
      end
      SEND_LO: begin
        if (OutReady) begin
          state_next = GET_MSW;
        end
      end
      default: state_next = GET_MSW;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      msw_q   <= '0;
      lsw_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (msw_load) begin
        msw_q <= InByte;
      end
      if (lsw_load) begin
        lsw_q <= InByte;
      end
      if (do_decode) begin
        hi_q <= {flags, 3'b000, data[10:8]};
        lo_q <= data[7:0];
        // Counters stick at all-ones rather than wrapping
        if (flags == F_SEC && sec_cnt != {CNT_W{1'b1}}) begin
          sec_cnt <= sec_cnt + 1'b1;
        end
        if (flags == F_DED && ded_cnt != {CNT_W{1'b1}}) begin
          ded_cnt <= ded_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    OutByte  = '0;
    if (Reset) begin
      case (state)
        GET_MSW, GET_LSW: InReady = 1'b1;
        SEND_HI: begin
          OutValid = 1'b1;
          OutByte  = hi_q;
        end
        SEND_LO: begin
          OutValid = 1'b1;
          OutByte  = lo_q;
        end
        default: begin
          InReady  = 1'b0;
          OutValid = 1'b0;
        end
      endcase
    end
  end

  assign SecCnt = sec_cnt;
  assign DedCnt = ded_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder using hand-decoded codewords.
module tb_hamming_decoder;

  logic       Clk;
  logic       Reset;
  logic [7:0] InByte;
  logic       InValid;
  logic       InReady;
  logic [7:0] OutByte;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] SecCnt;
  logic [7:0] DedCnt;

  int checks_total;
  int checks_passed;

  hamming_decoder #(.W(8), .CNT_W(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InByte   (InByte),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutByte  (OutByte),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .SecCnt   (SecCnt),
    .DedCnt   (DedCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge that consumed it
  task automatic put_byte(input logic [7:0] b, output bit ok);
    int n;
    n       = 0;
    ok      = 1'b0;
    InByte  = b;
    InValid = 1'b1;
    while (!InReady && n < 20) begin
      step();
      n++;
    end
    if (InReady) begin
      step();
      ok = 1'b1;
    end
    InValid = 1'b0;
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    b  = 8'hxx;
    while (!OutValid && n < 20) begin
      step();
      n++;
    end
    if (OutValid) begin
      b        = OutByte;
      OutReady = 1'b1;
      step();
      OutReady = 1'b0;
      ok       = 1'b1;
    end
  endtask

  task automatic run_word(input logic [7:0] msw, input logic [7:0] lsw,
                          output logic [7:0] hi, output logic [7:0] lo, output bit ok);
    bit ok1, ok2, ok3, ok4;
    put_byte(msw, ok1);
    put_byte(lsw, ok2);
    get_byte(hi, ok3);
    get_byte(lo, ok4);
    ok = ok1 && ok2 && ok3 && ok4;
  endtask

  task automatic test_reset();
    Reset    = 1'b0;
    InValid  = 1'b0;
    InByte   = 8'h00;
    OutReady = 1'b0;
    step();
    step();
    checks_total++;
    if (InReady !== 1'b0) $display("[TB] FAIL reset_inready: got %b expected 0", InReady);
    else checks_passed++;
    checks_total++;
    if (OutValid !== 1'b0 || OutByte !== 8'h00)
      $display("[TB] FAIL reset_out: got valid=%b byte=%h expected 0/00", OutValid, OutByte);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd0 || DedCnt !== 8'd0)
      $display("[TB] FAIL reset_counters: got sec=%0d ded=%0d expected 0/0", SecCnt, DedCnt);
    else checks_passed++;
    Reset = 1'b1;
    step();
    checks_total++;
    if (InReady !== 1'b1) $display("[TB] FAIL reset_release_inready: got %b expected 1", InReady);
    else checks_passed++;
  endtask

  task automatic test_clean();
    logic [7:0] hi, lo;
    bit ok;
    run_word(8'h00, 8'h0F, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h00 || lo !== 8'h01)
      $display("[TB] FAIL clean_word: got ok=%b %h %h expected 1 00 01", ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd0 || DedCnt !== 8'd0)
      $display("[TB] FAIL clean_counters: got sec=%0d ded=%0d expected 0/0", SecCnt, DedCnt);
    else checks_passed++;
  endtask

  task automatic test_single_error();
    logic [7:0] hi, lo;
    bit ok;
    run_word(8'h00, 8'h2F, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h40 || lo !== 8'h01)
      $display("[TB] FAIL sec_pos5: got ok=%b %h %h expected 1 40 01", ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd1) $display("[TB] FAIL sec_count: got %0d expected 1", SecCnt);
    else checks_passed++;
    // Error on a high data bit: b11 (pos15) flipped in an otherwise clean word
    run_word(8'h80, 8'h0F, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h40 || lo !== 8'h01)
      $display("[TB] FAIL sec_pos15: got ok=%b %h %h expected 1 40 01", ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd2) $display("[TB] FAIL sec_count2: got %0d expected 2", SecCnt);
    else checks_passed++;
  endtask

  task automatic test_p0_error();
    logic [7:0] hi, lo;
    bit ok;
    run_word(8'h00, 8'h0E, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h40 || lo !== 8'h01)
      $display("[TB] FAIL p0_only: got ok=%b %h %h expected 1 40 01", ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd3 || DedCnt !== 8'd0)
      $display("[TB] FAIL p0_counters: got sec=%0d ded=%0d expected 3/0", SecCnt, DedCnt);
    else checks_passed++;
  endtask

  task automatic test_double_error();
    logic [7:0] hi, lo;
    bit ok;
    run_word(8'h00, 8'h6F, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h80 || lo !== 8'h07)
      $display("[TB] FAIL ded_word: got ok=%b %h %h expected 1 80 07", ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd3 || DedCnt !== 8'd1)
      $display("[TB] FAIL ded_counters: got sec=%0d ded=%0d expected 3/1", SecCnt, DedCnt);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] hi, lo;
    bit ok1, ok2, ok3, ok4;
    int held_bad;
    put_byte(8'hFF, ok1);
    put_byte(8'hFF, ok2);
    checks_total++;
    if (!ok1 || !ok2 || OutValid !== 1'b0 || InReady !== 1'b0)
      $display("[TB] FAIL decode_cycle: got ok=%b%b valid=%b ready=%b expected 11 0 0",
               ok1, ok2, OutValid, InReady);
    else checks_passed++;
    step();
    checks_total++;
    if (OutValid !== 1'b1 || OutByte !== 8'h07)
      $display("[TB] FAIL hi_latency: got valid=%b byte=%h expected 1 07", OutValid, OutByte);
    else checks_passed++;
    // Offer a junk byte while stalled; it must not be taken
    InByte   = 8'hA5;
    InValid  = 1'b1;
    held_bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (OutValid !== 1'b1 || OutByte !== 8'h07 || InReady !== 1'b0) held_bad++;
    end
    checks_total++;
    if (held_bad != 0)
      $display("[TB] FAIL backpressure_hold: got %0d bad cycles, last valid=%b byte=%h ready=%b expected 0",
               held_bad, OutValid, OutByte, InReady);
    else checks_passed++;
    InValid = 1'b0;
    get_byte(hi, ok3);
    get_byte(lo, ok4);
    checks_total++;
    if (!ok3 || !ok4 || hi !== 8'h07 || lo !== 8'hFF)
      $display("[TB] FAIL all_ones: got ok=%b%b %h %h expected 11 07 FF", ok3, ok4, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd3 || DedCnt !== 8'd1)
      $display("[TB] FAIL all_ones_counters: got sec=%0d ded=%0d expected 3/1", SecCnt, DedCnt);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] hi, lo;
    bit ok;
    put_byte(8'h12, ok);
    Reset = 1'b0;
    step();
    checks_total++;
    if (!ok || OutValid !== 1'b0 || InReady !== 1'b0 || SecCnt !== 8'd0 || DedCnt !== 8'd0)
      $display("[TB] FAIL reset_mid: got ok=%b valid=%b ready=%b sec=%0d ded=%0d expected 1 0 0 0 0",
               ok, OutValid, InReady, SecCnt, DedCnt);
    else checks_passed++;
    Reset = 1'b1;
    step();
    checks_total++;
    if (OutValid !== 1'b0) $display("[TB] FAIL reset_mid_no_output: got %b expected 0", OutValid);
    else checks_passed++;
    run_word(8'h00, 8'h0F, hi, lo, ok);
    checks_total++;
    if (!ok || hi !== 8'h00 || lo !== 8'h01)
      $display("[TB] FAIL post_reset_word: got ok=%b %h %h expected 1 00 01", ok, hi, lo);
    else checks_passed++;
  endtask

  task automatic test_saturation();
    logic [7:0] hi, lo;
    bit ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 257; i++) begin
      run_word(8'h00, 8'h2F, hi, lo, ok);
      all_ok = all_ok && ok;
    end
    checks_total++;
    if (!all_ok || hi !== 8'h40 || lo !== 8'h01)
      $display("[TB] FAIL sat_data: got ok=%b %h %h expected 1 40 01", all_ok, hi, lo);
    else checks_passed++;
    checks_total++;
    if (SecCnt !== 8'd255) $display("[TB] FAIL sec_saturate: got %0d expected 255", SecCnt);
    else checks_passed++;
    checks_total++;
    if (DedCnt !== 8'd0) $display("[TB] FAIL sat_ded: got %0d expected 0", DedCnt);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    Reset    = 1'b0;
    InValid  = 1'b0;
    InByte   = 8'h00;
    OutReady = 1'b0;
    test_reset();
    test_clean();
    test_single_error();
    test_p0_error();
    test_double_error();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
